bp_me_wormhole_mem_cmd_rx: RTL

BP_ME_WORMHOLE_MEM_CMD_RX -- requirements
Module: bp_me_wormhole_mem_cmd_rx

---
 rtl/bp_me_wormhole_mem_cmd_rx_if.sv | 39 +++
 rtl/bp_me_wormhole_mem_cmd_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_wormhole_mem_cmd_rx_if.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_mem_cmd_rx_if
//   Bundles the wormhole link side and the reassembled mem_cmd side of the
//   receiver into one interface.
//   slave  : the receiver (consumes link flits, produces mem_cmd)
//   master : the environment (drives flits, consumes mem_cmd)
//   Signals:
//     link_data_i / link_v_i / link_ready_o   incoming flit handshake
//     mem_cmd_o / mem_cmd_v_o / mem_cmd_ready_i  {data, header} command out
//     src_cord_o / src_cid_o                   source of the held packet
//     len_err_o                                illegal-length pulse
// ---------------------------------------------------------------------------
interface bp_me_wormhole_mem_cmd_rx_if #(
    parameter int flit_width_p   = 32,
    parameter int cord_width_p   = 8,
    parameter int cid_width_p    = 4,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 512
);
    logic [flit_width_p-1:0]                link_data_i;
    logic                                   link_v_i;
    logic                                   link_ready_o;
    logic [header_width_p+data_width_p-1:0] mem_cmd_o;
    logic                                   mem_cmd_v_o;
    logic                                   mem_cmd_ready_i;
    logic [cord_width_p-1:0]                src_cord_o;
    logic [cid_width_p-1:0]                 src_cid_o;
    logic                                   len_err_o;

    modport slave (
        input  link_data_i, link_v_i, mem_cmd_ready_i,
        output link_ready_o, mem_cmd_o, mem_cmd_v_o, src_cord_o, src_cid_o, len_err_o
    );

    modport master (
        output link_data_i, link_v_i, mem_cmd_ready_i,
        input  link_ready_o, mem_cmd_o, mem_cmd_v_o, src_cord_o, src_cid_o, len_err_o
    );
endinterface

// File: rtl/bp_me_wormhole_mem_cmd_rx.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_mem_cmd_rx
//   Reassembles a wormhole packet (header flit + len body flits) into a
//   memory command. Packet layout, LSB first:
//     cord, cid, len, src_cord, src_cid, header, data
//   Flit k lands in buffer slot k; slots never written stay zero so short
//   packets (reads, partial writes) come out zero-filled.
//   Ports:
//     clk_i      clock, all state on rising edge
//     reset_n_i  asynchronous active-low reset
//     io         slave side of bp_me_wormhole_mem_cmd_rx_if
// ---------------------------------------------------------------------------
module bp_me_wormhole_mem_cmd_rx #(
    parameter int flit_width_p   = 32,
    parameter int cord_width_p   = 8,
    parameter int cid_width_p    = 4,
    parameter int len_width_p    = 5,
    parameter int header_width_p = 64,
    parameter int data_width_p   = 512
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bp_me_wormhole_mem_cmd_rx_if.slave     io
);

    localparam int pkt_width_lp = 2*cord_width_p + 2*cid_width_p + len_width_p
                                + header_width_p + data_width_p;
    localparam int max_flits_lp = (pkt_width_lp + flit_width_p - 1) / flit_width_p;
    localparam int max_len_lp   = max_flits_lp - 1;

    localparam int CNT_W  = $clog2(max_flits_lp + 1);
    localparam int LENX_W = len_width_p + 1;
    localparam int BUF_W  = max_flits_lp * flit_width_p;
    localparam int PAD_W  = BUF_W - pkt_width_lp;
    localparam int CMD_W  = header_width_p + data_width_p;

    // field offsets within the reassembled packet
    localparam int OFF_LEN   = cord_width_p + cid_width_p;
    localparam int OFF_SCORD = OFF_LEN + len_width_p;
    localparam int OFF_SCID  = OFF_SCORD + cord_width_p;
    localparam int OFF_HDR   = OFF_SCID + cid_width_p;

    typedef enum logic [1:0] {
        e_ready,
        e_body,
        e_out,
        e_drain
    } state_e;

    state_e                                    r_state;
    state_e                                    w_state_nxt;
    logic [CNT_W-1:0]                          r_count;
    logic [LENX_W-1:0]                         r_dcount;
    logic [LENX_W-1:0]                         r_len;
    logic                                      r_len_err;
    logic [max_flits_lp-1:0][flit_width_p-1:0] r_buf;

    logic                    w_fire;
    logic [len_width_p-1:0]  w_len;
    logic                    w_len_bad;
    logic                    w_body_last;
    logic                    w_drain_last;
    logic                    w_link_ready;
    logic                    w_mem_v;
    logic                    w_wr;
    logic                    w_clr;
    logic [CNT_W-1:0]        w_idx;
    logic [BUF_W-1:0]        w_pkt;
    logic                    w_unused_bits;

    assign w_fire       = io.link_v_i & io.link_ready_o;
    assign w_len        = io.link_data_i[OFF_LEN +: len_width_p];
    assign w_len_bad    = int'(w_len) > max_len_lp;
    assign w_body_last  = int'(r_count) == int'(r_len);
    assign w_drain_last = int'(r_dcount) == int'(r_len);
    // the header always goes to slot 0; r_count is stale while idle
    assign w_idx        = (r_state == e_ready) ? '0 : r_count;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= e_ready;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_link_ready = 1'b0;
        w_mem_v      = 1'b0;
        w_wr         = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            e_ready: begin
                w_link_ready = 1'b1;
                if (w_fire) begin
                    w_wr = 1'b1;
                    if (w_len == '0)    w_state_nxt = e_out;
                    else if (w_len_bad) w_state_nxt = e_drain;
                    else                w_state_nxt = e_body;
                end
            end
            e_body: begin
                w_link_ready = 1'b1;
                if (w_fire) begin
                    w_wr = 1'b1;
                    if (w_body_last) w_state_nxt = e_out;
                end
            end
            e_out: begin
                w_mem_v = 1'b1;
                if (io.mem_cmd_ready_i) begin
                    w_clr       = 1'b1;
                    w_state_nxt = e_ready;
                end
            end
            e_drain: begin
                // flits are swallowed without touching the buffer
                w_link_ready = 1'b1;
                if (w_fire && w_drain_last) w_state_nxt = e_ready;
            end
            default: w_state_nxt = e_ready;
        endcase
    end

    // -----------------------------------------------------------------------
    // counters, latched length, error pulse
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count   <= '0;
            r_dcount  <= '0;
            r_len     <= '0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= (r_state == e_ready) && w_fire && w_len_bad;
            if (r_state == e_ready && w_fire) begin
                r_count  <= CNT_W'(1);
                r_dcount <= LENX_W'(1);
                r_len    <= {1'b0, w_len};
            end else if (r_state == e_body && w_fire) begin
                r_count  <= r_count + CNT_W'(1);
            end else if (r_state == e_drain && w_fire) begin
                r_dcount <= r_dcount + LENX_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // flit buffer: cleared when the command leaves so the next packet's
    // unreceived slots read as zero
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_buf <= '0;
        end else if (w_clr) begin
            r_buf <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < max_flits_lp; i++) begin
                if (w_idx == CNT_W'(i)) r_buf[i] <= io.link_data_i;
            end
        end
    end

    assign w_pkt = r_buf;

    // destination cord/cid, len and any tail padding are not forwarded
    if (PAD_W > 0) begin : g_pad
        assign w_unused_bits = ^{w_pkt[BUF_W-1 -: PAD_W], w_pkt[OFF_SCORD-1:0]};
    end else begin : g_nopad
        assign w_unused_bits = ^w_pkt[OFF_SCORD-1:0];
    end

    // -----------------------------------------------------------------------
    // outputs
    // -----------------------------------------------------------------------
    // ready is gated by the raw reset so it is low for the whole reset window
    assign io.link_ready_o = reset_n_i & w_link_ready;
    assign io.mem_cmd_v_o  = w_mem_v;
    assign io.mem_cmd_o    = w_pkt[OFF_HDR +: CMD_W];
    assign io.src_cord_o   = w_pkt[OFF_SCORD +: cord_width_p];
    assign io.src_cid_o    = w_pkt[OFF_SCID +: cid_width_p];
    assign io.len_err_o    = r_len_err;

endmodule
